vp_frame_writer: RTL

- Downstream consumer of the video-process output stream (vp_vs / vp_de / vp_data, RGB565, on the video-process clock).
- Packs pixel pairs into 32-bit words and buffers them in a small internal FIFO.
- Writes each frame into one of two ping-pong frame buffers using fixed-length write bursts on a generic memory-write port.
- Reports completed frames and which buffer is safe for display readout.

---
 rtl/vp_pkg.sv | 26 ++
 rtl/vp_word_fifo.sv | 62 ++++++
 rtl/vp_frame_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vp_pkg.sv
// vp_pkg: shared types and constants for the video-process frame writer.
//   rgb565_t      - packed RGB565 pixel
//   frame_words() - 32-bit words per frame (two pixels per word)
//   FB*_DEFAULT   - default byte base addresses of the ping-pong buffers
//   burst_state_t - burst FSM states
package vp_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [31:0] FB0_BASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] FB1_BASE_DEFAULT = 32'h0020_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
    return (h * v) / 2;
  endfunction

endpackage

// File: rtl/vp_word_fifo.sv
// vp_word_fifo: single-clock show-ahead FIFO.
//   clk, rst_n - clock, async active-low reset
//   clr_i      - synchronous flush (wins over push/pop)
//   push_i     - write wdata_i; ignored while full
//   pop_i      - advance head; ignored while empty
//   rdata_o    - current head word (valid while !empty_o)
//   count_o    - number of stored words
//   full_o, empty_o - status flags
module vp_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; only slots behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vp_frame_writer.sv
// vp_frame_writer: packs RGB565 pixel pairs into 32-bit words, buffers them,
// and writes each frame into one of two ping-pong buffers with fixed-length
// write bursts.
//   clk, rst_n            - clock, async active-low reset
//   enable                - capture enable, sampled at frame start
//   vp_vs/vp_de/vp_data   - video-process stream (rising vs = frame start)
//   mem_req/addr/wdata/last, mem_ready - burst write port
//   frame_done            - pulse after the last word of a frame is accepted
//   frame_err             - pulse at frame start if previous frame incomplete
//   rd_fb_sel             - buffer holding the last complete frame
//   overflow              - sticky word-drop flag, cleared at frame start
module vp_frame_writer
  import vp_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8,
  parameter logic [ADDR_WIDTH-1:0] FB0_BASE = ADDR_WIDTH'(FB0_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] FB1_BASE = ADDR_WIDTH'(FB1_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  vp_vs,
  input  logic                  vp_de,
  input  logic [15:0]           vp_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_last,
  input  logic                  mem_ready,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  rd_fb_sel,
  output logic                  overflow
);

  localparam int FRAME_WORDS = frame_words(H_DISP, V_DISP);
  localparam int WC_W        = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FCNT_W      = $clog2(FIFO_DEPTH) + 1;

  // Front end: sync detection and pixel packing
  logic            vs_q, vs_qq, vs_rise;
  logic            flush_pending_q, armed_q, frame_err_q, overflow_q;
  rgb565_t         pix_lo_q;
  logic            has_lo_q, push_q;
  logic [31:0]     word_q;
  logic [WC_W-1:0] words_packed_q;
  logic            flush_fire, pix_take;

  // Burst engine
  burst_state_t          state_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WC_W-1:0]       words_issued_q, words_issued_d;
  logic                  mem_req_q, mem_last_q, frame_done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, wr_base;
  logic                  rd_fb_sel_q, wr_fb_sel_q, done_this_frame_q;
  logic                  beat_accept, last_beat, frame_complete;

  // FIFO interface
  logic [31:0]       fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;

  assign vs_rise        = vs_q & ~vs_qq;
  assign flush_fire     = flush_pending_q && (state_q == IDLE);
  assign pix_take       = vp_de && armed_q && !flush_pending_q &&
                          (words_packed_q < WC_W'(FRAME_WORDS));
  assign beat_accept    = mem_req_q && mem_ready;
  assign last_beat      = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign frame_complete = beat_accept && (words_issued_q == WC_W'(FRAME_WORDS - 1));
  assign beat_d         = beat_q + 1'b1;
  assign words_issued_d = words_issued_q + 1'b1;
  assign wr_base        = wr_fb_sel_q ? FB1_BASE : FB0_BASE;

  vp_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_fire),
    .push_i  (push_q),
    .wdata_i (word_q),
    .pop_i   (beat_accept),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Frame-start handling and pixel packing. A frame completing in the same
  // cycle as the vs edge still counts as complete, so frame_err is masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q            <= 1'b0;
      vs_qq           <= 1'b0;
      flush_pending_q <= 1'b0;
      armed_q         <= 1'b0;
      frame_err_q     <= 1'b0;
      overflow_q      <= 1'b0;
      pix_lo_q        <= '0;
      has_lo_q        <= 1'b0;
      push_q          <= 1'b0;
      word_q          <= '0;
      words_packed_q  <= '0;
    end else begin
      vs_q        <= vp_vs;
      vs_qq       <= vs_q;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      if (flush_fire) begin
        flush_pending_q <= 1'b0;
        armed_q         <= enable;
        has_lo_q        <= 1'b0;
        words_packed_q  <= '0;
        overflow_q      <= 1'b0;
      end else begin
        if (push_q && fifo_full) overflow_q <= 1'b1;
        if (pix_take) begin
          if (!has_lo_q) begin
            pix_lo_q <= vp_data;
            has_lo_q <= 1'b1;
          end else begin
            word_q         <= {vp_data, pix_lo_q};
            push_q         <= 1'b1;
            has_lo_q       <= 1'b0;
            words_packed_q <= words_packed_q + 1'b1;
          end
        end
      end
      if (vs_rise) begin
        flush_pending_q <= 1'b1;
        frame_err_q     <= armed_q && !done_this_frame_q && !frame_complete;
      end
    end
  end

  // Burst FSM with registered request, address and last flag. A burst only
  // starts with BURST_LEN words already buffered, so the head never runs dry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      beat_q            <= '0;
      words_issued_q    <= '0;
      mem_req_q         <= 1'b0;
      mem_addr_q        <= FB0_BASE;
      mem_last_q        <= 1'b0;
      frame_done_q      <= 1'b0;
      rd_fb_sel_q       <= 1'b0;
      wr_fb_sel_q       <= 1'b0;
      done_this_frame_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_fire) begin
            words_issued_q    <= '0;
            done_this_frame_q <= 1'b0;
          end else if (!flush_pending_q && !fifo_empty &&
                       (fifo_count >= FCNT_W'(BURST_LEN)) &&
                       (words_issued_q < WC_W'(FRAME_WORDS))) begin
            state_q    <= BURST;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= wr_base + (ADDR_WIDTH'(words_issued_q) << 2);
            mem_last_q <= (BURST_LEN == 1);
          end
        end
        BURST: begin
          if (mem_ready) begin
            words_issued_q <= words_issued_d;
            if (last_beat) begin
              state_q    <= IDLE;
              mem_req_q  <= 1'b0;
              mem_last_q <= 1'b0;
            end else begin
              beat_q     <= beat_d;
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
              mem_last_q <= (beat_d == BEAT_W'(BURST_LEN - 1));
            end
            if (frame_complete) begin
              frame_done_q      <= 1'b1;
              rd_fb_sel_q       <= wr_fb_sel_q;
              wr_fb_sel_q       <= ~wr_fb_sel_q;
              done_this_frame_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write data is the show-ahead FIFO head, forced to zero outside a burst.
  assign mem_wdata  = ((state_q == BURST) && !fifo_empty) ? fifo_rdata : 32'h0;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_last   = mem_last_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign rd_fb_sel  = rd_fb_sel_q;
  assign overflow   = overflow_q;

endmodule
